spi_xfer_sequencer: RTL
=======================

// Module: spi_xfer_sequencer
// PURPOSE
//  Sequences multi-byte SPI transfers on top of the single-byte exchanger.
//  Accepts a command (CS index, byte count, keep-CS flag) and drives chip-select timing.
//  Streams TX bytes into the exchanger and RX bytes out, one per byte, with valid/ready flow control.
//  Sits between the AXI-lite register/FIFO layer and the byte exchanger, in the clk_i domain.
// PARAMETERS
//  BYTE      8     data width of one exchange
//  NUM_CS    4     number of chip-select lines
//  CS_W      2     width of the CS index, clog2(NUM_CS)
//  LEN_W     8     command length width; a command moves len+1 bytes
//  CS_SETUP  4     clk_i cycles from CS assert to first exchange start (>=1)
//  CS_HOLD   4     clk_i cycles from last byte done to CS deassert (>=1)
//  TMO_CYC   1024  watchdog limit in clk_i cycles (only with SPI_SEQ_TIMEOUT_EN)
// PORTS
//  clk_i          in   1       system clock
//  arst_n_i       in   1       asynchronous reset, active-low
//  soft_rst_i     in   1       synchronous abort/reset, returns FSM to IDLE
//  cmd_valid_i    in   1       command request
//  cmd_ready_o    out  1       command accepted when valid&ready
//  cmd_cs_i       in   CS_W    target chip-select index
//  cmd_len_i      in   LEN_W   byte count minus one
//  cmd_keep_cs_i  in   1       1: leave CS asserted after the command
//  tx_data_i      in   BYTE    next TX byte
//  tx_valid_i     in   1       TX byte available
//  tx_ready_o     out  1       TX byte consumed when valid&ready
//  rx_data_o      out  BYTE    received byte
//  rx_valid_o     out  1       RX byte available
//  rx_ready_i     in   1       RX sink accepts
//  exch_start_o   out  1       one-cycle exchange pulse to the exchanger
//  exch_data_o    out  BYTE    byte to exchanger; valid in the cycle of exch_start_o
//  exch_busy_i    in   1       exchanger busy
//  exch_ready_i   in   1       exchanger one-cycle completion pulse
//  exch_data_i    in   BYTE    exchanger result, valid with exch_ready_i
//  cs_n_o         out  NUM_CS  chip selects, active-low, one-hot-low or all high
//  busy_o         out  1       high in any state except IDLE
//  done_o         out  1       one-cycle pulse at command completion
// BEHAVIOUR
//  Reset and soft_rst_i:
//   - all outputs 0, except cs_n_o='1 and cmd_ready_o=1; FSM goes to IDLE.
//   - soft_rst_i mid-transfer: CS released next cycle; RX byte dropped.
//   - The exchanger finishes its own byte; its ready pulse is ignored in IDLE.
//  FSM states: IDLE, SETUP, FETCH, START, WAIT, STORE, HOLD, DONE.
//   - IDLE: cmd_ready_o=1. On cmd_valid_i, latch cs/len/keep and clear byte counter.
//     If the same CS is already held low (keep), go to FETCH; otherwise drive cs_n_o[cs]=0 and go to SETUP.
//   - SETUP: count CS_SETUP cycles, then go to FETCH.
//   - FETCH: tx_ready_o=1. On tx_valid_i, register tx_data_i into exch_data_o and go to START.
//   - START: exch_start_o=1 for exactly one cycle, and only if exch_busy_i=0; otherwise stay in START. Then go to WAIT.
//   - WAIT: on exch_ready_i, register exch_data_i into rx_data_o, set rx_valid_o, go to STORE.
//   - STORE: hold rx_valid_o until rx_ready_i, then increment the counter.
//     If counter==len go to HOLD, else go to FETCH.
//   - HOLD: count CS_HOLD cycles. If keep=0, deassert CS. Then go to DONE.
//   - DONE: done_o=1 for one cycle, then go to IDLE.
//  Latency, best case with no back-pressure: FETCH->START->WAIT gives 2 cycles + exchanger time per byte.
//  Boundaries:
//   - cmd_len_i=0 gives a single-byte transfer.
//   - cmd_len_i='1 gives 2^LEN_W bytes; the counter is LEN_W+1 bits wide, no wrap.
//   - A new command with a different CS while keep is held: release the old CS for one cycle, then SETUP.
//   - exch_ready_i outside WAIT is ignored.
//   - A command arriving during DONE is not accepted until IDLE.
// CONFIGURATION
//  SPI_SEQ_TIMEOUT_EN defined:
//   - adds output err_tmo_o (reset 0).
//   - the watchdog counts cycles spent in WAIT.
//   - on reaching TMO_CYC: pulse err_tmo_o, release CS, pulse done_o, return to IDLE.
//  SPI_SEQ_TIMEOUT_EN undefined: no port, no counter; WAIT waits forever.
// STRUCTURE
//  Package spi_pkg:
//   - state encoding localparams;
//   - CS_IDLE_ALL='1;
//   - shared BYTE default.
//  Sub-module spi_seq_delay: loadable down-counter shared by SETUP and HOLD (and the timeout).
// TESTING
//  - len=3, cs=1, keep=0, TX A5,3C,FF,00, exchanger loops TX back:
//    RX A5,3C,FF,00; cs_n_o=4'b1101 for the whole command; one done_o pulse.
//  - len=0, tx_valid_i withheld 20 cycles:
//    stays in FETCH, no exch_start_o; one byte is exchanged once valid arrives.
//  - rx_ready_i low 10 cycles after the first byte:
//    rx_valid_o/rx_data_o stable; no second exch_start_o until accepted.
//  - keep=1 on cs=2, then a second command on cs=2:
//    CS stays low with no SETUP gap.
//  - keep=1 on cs=2, then a command on cs=0:
//    cs_n_o goes 1111 for 1 cycle, then 1110.
//  - soft_rst_i asserted during WAIT: next cycle cs_n_o=1111, busy_o=0, cmd_ready_o=1.
//  - With SPI_SEQ_TIMEOUT_EN, exchanger never readies: err_tmo_o pulses at cycle 1024 of WAIT.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and constants for the SPI transfer sequencer
package spi_pkg;

  // Default width of one SPI exchange.
  localparam int BYTE_DEF = 8;

  // All chip selects released; sliced down to the real CS count by users.
  localparam logic [31:0] CS_IDLE_ALL = '1;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5,
    ST_HOLD  = 3'd6,
    ST_DONE  = 3'd7
  } seq_state_e;

endpackage

// File: rtl/spi_seq_delay.sv
// rtl/spi_seq_delay.sv - loadable down-counter timing CS setup/hold and the WAIT watchdog
module spi_seq_delay #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; the counter parks at zero once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - multi-byte SPI transfer sequencer; SPI_SEQ_TIMEOUT_EN adds a WAIT watchdog
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int BYTE     = BYTE_DEF,
  parameter int NUM_CS   = 4,
  parameter int CS_W     = $clog2(NUM_CS),
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_CYC  = 1024
`endif
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              soft_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CS_W-1:0]   cmd_cs_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              cmd_keep_cs_i,
  input  logic [BYTE-1:0]   tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [BYTE-1:0]   rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              exch_start_o,
  output logic [BYTE-1:0]   exch_data_o,
  input  logic              exch_busy_i,
  input  logic              exch_ready_i,
  input  logic [BYTE-1:0]   exch_data_i,
  output logic [NUM_CS-1:0] cs_n_o,
  output logic              busy_o,
`ifdef SPI_SEQ_TIMEOUT_EN
  output logic              err_tmo_o,
`endif
  output logic              done_o
);

  localparam int SH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int DLY_MAX = (TMO_CYC > SH_MAX) ? TMO_CYC : SH_MAX;
`else
  localparam int DLY_MAX = SH_MAX;
`endif
  localparam int DLY_W = $clog2(DLY_MAX + 1);
  localparam logic [NUM_CS-1:0] CS_OFF = CS_IDLE_ALL[NUM_CS-1:0];

  // Active-low one-hot chip-select pattern for a CS index.
  function automatic logic [NUM_CS-1:0] cs_sel_n(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] v;
    v      = CS_OFF;
    v[idx] = 1'b0;
    return v;
  endfunction

  seq_state_e         state_q, state_d;
  logic [CS_W-1:0]    cs_q, cs_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               keep_q, keep_d;
  logic [LEN_W:0]     cnt_q, cnt_d;
  logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
  logic [BYTE-1:0]    exch_data_q, exch_data_d;
  logic [BYTE-1:0]    rx_data_q, rx_data_d;
  logic               dly_load, dly_zero;
  logic [DLY_W-1:0]   dly_val;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic               err_tmo_q, err_tmo_d;
`endif

  spi_seq_delay #(.W(DLY_W)) u_delay (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .clr_i      (soft_rst_i),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .zero_o     (dly_zero)
  );

  // Next-state, chip-select and datapath decisions; soft reset overrides everything.
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    len_d       = len_q;
    keep_d      = keep_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    exch_data_d = exch_data_q;
    rx_data_d   = rx_data_q;
    dly_load    = 1'b0;
    dly_val     = '0;
`ifdef SPI_SEQ_TIMEOUT_EN
    err_tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cs_d   = cmd_cs_i;
          len_d  = cmd_len_i;
          keep_d = cmd_keep_cs_i;
          cnt_d  = '0;
          if (cs_n_q == CS_OFF) begin
            cs_n_d   = cs_sel_n(cmd_cs_i);
            dly_load = 1'b1;
            dly_val  = DLY_W'(CS_SETUP - 1);
            state_d  = ST_SETUP;
          end else if (!cs_n_q[cmd_cs_i]) begin
            state_d = ST_FETCH;
          end else begin
            // Another CS is still held: release it for one cycle first, so
            // SETUP runs one extra cycle to keep the full CS-low setup time.
            cs_n_d   = CS_OFF;
            dly_load = 1'b1;
            dly_val  = DLY_W'(CS_SETUP);
            state_d  = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        cs_n_d = cs_sel_n(cs_q);
        if (dly_zero) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (tx_valid_i) begin
          exch_data_d = tx_data_i;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (!exch_busy_i) begin
          state_d = ST_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
          dly_load = 1'b1;
          dly_val  = DLY_W'(TMO_CYC - 1);
`endif
        end
      end
      ST_WAIT: begin
        if (exch_ready_i) begin
          rx_data_d = exch_data_i;
          state_d   = ST_STORE;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (dly_zero) begin
          cs_n_d    = CS_OFF;
          err_tmo_d = 1'b1;
          state_d   = ST_DONE;
        end
`endif
      end
      ST_STORE: begin
        if (rx_ready_i) begin
          cnt_d = cnt_q + (LEN_W + 1)'(1);
          if (cnt_q == {1'b0, len_q}) begin
            dly_load = 1'b1;
            dly_val  = DLY_W'(CS_HOLD - 1);
            state_d  = ST_HOLD;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        if (dly_zero) begin
          if (!keep_q) cs_n_d = CS_OFF;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (soft_rst_i) begin
      state_d     = ST_IDLE;
      cs_n_d      = CS_OFF;
      cnt_d       = '0;
      exch_data_d = '0;
      rx_data_d   = '0;
      dly_load    = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_tmo_d   = 1'b0;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_IDLE;
      cs_q        <= '0;
      len_q       <= '0;
      keep_q      <= 1'b0;
      cnt_q       <= '0;
      cs_n_q      <= CS_OFF;
      exch_data_q <= '0;
      rx_data_q   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      len_q       <= len_d;
      keep_q      <= keep_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      exch_data_q <= exch_data_d;
      rx_data_q   <= rx_data_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_tmo_q   <= err_tmo_d;
`endif
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign tx_ready_o   = (state_q == ST_FETCH);
  assign exch_start_o = (state_q == ST_START) && !exch_busy_i;
  assign exch_data_o  = exch_data_q;
  assign rx_valid_o   = (state_q == ST_STORE);
  assign rx_data_o    = rx_data_q;
  assign cs_n_o       = cs_n_q;
  assign done_o       = (state_q == ST_DONE);
`ifdef SPI_SEQ_TIMEOUT_EN
  assign err_tmo_o    = err_tmo_q;
`endif

endmodule
